// File: rtl/transmission_estimator_if.sv
`default_nettype none
// transmission_estimator_if: pixel stream, atmospheric-light handoff and transmission outputs.
// The t_min/t_max members exist only when TE_FRAME_STATS_EN is defined.
interface transmission_estimator_if;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic [7:0]  A_R;
  logic [7:0]  A_G;
  logic [7:0]  A_B;
  logic [15:0] Inv_A_R;
  logic [15:0] Inv_A_G;
  logic [15:0] Inv_A_B;
  logic        ale_valid;
  logic [23:0] output_pixel;
  logic [7:0]  transmission;
  logic        output_is_valid;
  logic        frame_done;
  logic        drop_err;
`ifdef TE_FRAME_STATS_EN
  logic [7:0]  t_min;
  logic [7:0]  t_max;
`endif

  modport master (
    output input_pixel, input_is_valid, A_R, A_G, A_B,
    output Inv_A_R, Inv_A_G, Inv_A_B, ale_valid,
    input  output_pixel, transmission, output_is_valid, frame_done, drop_err
`ifdef TE_FRAME_STATS_EN
    , input t_min, t_max
`endif
  );

  modport slave (
    input  input_pixel, input_is_valid, A_R, A_G, A_B,
    input  Inv_A_R, Inv_A_G, Inv_A_B, ale_valid,
    output output_pixel, transmission, output_is_valid, frame_done, drop_err
`ifdef TE_FRAME_STATS_EN
    , output t_min, t_max
`endif
  );
endinterface
`default_nettype wire

// File: rtl/transmission_estimator.sv
`default_nettype none
// transmission_estimator: t = max(T0, 255 - OMEGA*min_c(I_c/A_c)) in Q0.8, 4-cycle pipeline.
// Define TE_FRAME_STATS_EN to add per-frame t_min/t_max outputs.
module transmission_estimator #(
  parameter int NUM_PIXELS = 262144,
  parameter int OMEGA      = 243,
  parameter int T0         = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  transmission_estimator_if.slave bus
);

  localparam int               CNT_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [7:0]       OMEGA_Q8  = 8'(OMEGA);
  localparam logic [7:0]       T0_Q8     = 8'(T0);
  localparam logic [0:0]       ST_WAIT_A = 1'b0;
  localparam logic [0:0]       ST_RUN    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [47:0]      inv_q, inv_d;
  logic [47:0]      pend_inv_q, pend_inv_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic             accept, eof;
  logic [47:0]      new_inv;

  assign new_inv = {bus.Inv_A_R, bus.Inv_A_G, bus.Inv_A_B};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    pend_inv_d = pend_inv_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    accept     = 1'b0;
    eof        = 1'b0;
    case (state_q)
      ST_WAIT_A: begin
        if (bus.input_is_valid) drop_d = 1'b1;
        if (bus.ale_valid) begin
          inv_d   = new_inv;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.input_is_valid) begin
          accept = 1'b1;
          if (cnt_q == LAST_IDX) begin
            eof   = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Active values only change at a frame boundary; mid-frame updates wait in pending.
        if (eof) begin
          if (pend_q) begin
            inv_d  = pend_inv_q;
            pend_d = bus.ale_valid;
            if (bus.ale_valid) pend_inv_d = new_inv;
          end else if (bus.ale_valid) begin
            inv_d = new_inv;
          end else begin
            state_d = ST_WAIT_A;
          end
        end else if (bus.ale_valid) begin
          pend_inv_d = new_inv;
          pend_d     = 1'b1;
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_WAIT_A;
      cnt_q      <= '0;
      inv_q      <= '0;
      pend_inv_q <= '0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      pend_inv_q <= pend_inv_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  // The low byte of I*Inv never reaches the result, so stage 1 keeps only p >> 8.
  function automatic logic [15:0] scale(input logic [7:0] i, input logic [15:0] inv);
    logic [23:0] p;
    p = {16'd0, i} * {8'd0, inv};
    return 16'(p >> 8);
  endfunction

  function automatic logic [7:0] sat8(input logic [15:0] n);
    return (|n[15:8]) ? 8'hFF : n[7:0];
  endfunction

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] ab;
    ab = (a < b) ? a : b;
    return (ab < c) ? ab : c;
  endfunction

  logic        v1_q, v2_q, v3_q, eof1_q, eof2_q, eof3_q;
  logic [23:0] pix1_q, pix2_q, pix3_q;
  logic [15:0] nr1_q, ng1_q, nb1_q;
  logic [7:0]  m2_q, k3_q;
  logic        out_v_q, fd_q;
  logic [23:0] opix_q;
  logic [7:0]  t_q;
  logic [7:0]  t_raw, t_clamped;

  assign t_raw     = 8'd255 - k3_q;
  assign t_clamped = (t_raw < T0_Q8) ? T0_Q8 : t_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      eof1_q <= 1'b0; eof2_q <= 1'b0; eof3_q <= 1'b0;
      pix1_q <= '0; pix2_q <= '0; pix3_q <= '0;
      nr1_q <= '0; ng1_q <= '0; nb1_q <= '0;
      m2_q <= '0; k3_q <= '0;
      out_v_q <= 1'b0; fd_q <= 1'b0; opix_q <= '0; t_q <= '0;
    end else begin
      v1_q    <= accept;
      eof1_q  <= accept & eof;
      v2_q    <= v1_q;
      eof2_q  <= eof1_q;
      v3_q    <= v2_q;
      eof3_q  <= eof2_q;
      out_v_q <= v3_q;
      fd_q    <= eof3_q;
      if (accept) begin
        pix1_q <= bus.input_pixel;
        nr1_q  <= scale(bus.input_pixel[23:16], inv_q[47:32]);
        ng1_q  <= scale(bus.input_pixel[15:8],  inv_q[31:16]);
        nb1_q  <= scale(bus.input_pixel[7:0],   inv_q[15:0]);
      end
      if (v1_q) begin
        pix2_q <= pix1_q;
        m2_q   <= min3(sat8(nr1_q), sat8(ng1_q), sat8(nb1_q));
      end
      if (v2_q) begin
        pix3_q <= pix2_q;
        k3_q   <= 8'(({8'd0, OMEGA_Q8} * {8'd0, m2_q}) >> 8);
      end
      if (v3_q) begin
        opix_q <= pix3_q;
        t_q    <= t_clamped;
      end
    end
  end

  assign bus.output_pixel    = opix_q;
  assign bus.transmission    = t_q;
  assign bus.output_is_valid = out_v_q;
  assign bus.frame_done      = fd_q;
  assign bus.drop_err        = drop_q;

`ifdef TE_FRAME_STATS_EN
  logic       first_q;
  logic [7:0] tmin_q, tmax_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= 1'b1;
      tmin_q  <= '0;
      tmax_q  <= '0;
    end else if (v3_q) begin
      if (first_q) begin
        tmin_q <= t_clamped;
        tmax_q <= t_clamped;
      end else begin
        if (t_clamped < tmin_q) tmin_q <= t_clamped;
        if (t_clamped > tmax_q) tmax_q <= t_clamped;
      end
      first_q <= eof3_q;
    end
  end

  assign bus.t_min = tmin_q;
  assign bus.t_max = tmax_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transmission_estimator.sv
`default_nettype none
// tb_transmission_estimator: directed and random pixel/A streams checked through a scoreboard
// against an arithmetic reference of the transmission formula and frame bookkeeping.
module tb_transmission_estimator;
  localparam int NP    = 4;
  localparam int OMEGA = 243;
  localparam int T0    = 26;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  transmission_estimator_if bus();

  transmission_estimator #(.NUM_PIXELS(NP), .OMEGA(OMEGA), .T0(T0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0] pix;
    logic [7:0]  t;
    logic        eof;
    logic [31:0] cyc;
  } exp_s;

  exp_s sbq[$];
  exp_s mon_e;

  // Reference model state: whether A is held, active/pending reciprocals, frame position.
  bit have_a, pend_v, exp_drop;
  int act_r, act_g, act_b, pnd_r, pnd_g, pnd_b, cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_t(input int r, input int g, input int b,
                               input int ir, input int ig, input int ib);
    int nr, ng, nb, m, k, t;
    nr = (r * ir) / 256; if (nr > 255) nr = 255;
    ng = (g * ig) / 256; if (ng > 255) ng = 255;
    nb = (b * ib) / 256; if (nb > 255) nb = 255;
    m = nr;
    if (ng < m) m = ng;
    if (nb < m) m = nb;
    k = (OMEGA * m) / 256;
    t = 255 - k;
    if (t < T0) t = T0;
    return t;
  endfunction

`ifdef TE_FRAME_STATS_EN
  bit s_first = 1'b1;
  int s_min, s_max;
`endif

  always @(negedge clk) begin
    if (rst) begin
      if (bus.output_is_valid && sbq.size() == 0) begin
        check("unexpected_valid", 32'(bus.output_is_valid), 32'd0);
      end else if (bus.output_is_valid) begin
        mon_e = sbq.pop_front();
        check("output_pixel", 32'(bus.output_pixel), 32'(mon_e.pix));
        check("transmission", 32'(bus.transmission), 32'(mon_e.t));
        check("frame_done", 32'(bus.frame_done), 32'(mon_e.eof));
        check("latency", cyc - mon_e.cyc, 32'd4);
`ifdef TE_FRAME_STATS_EN
        if (s_first) begin
          s_min = mon_e.t; s_max = mon_e.t;
        end else begin
          if (mon_e.t < s_min) s_min = mon_e.t;
          if (mon_e.t > s_max) s_max = mon_e.t;
        end
        s_first = mon_e.eof;
        check("t_min", 32'(bus.t_min), s_min);
        check("t_max", 32'(bus.t_max), s_max);
`endif
      end else begin
        check("frame_done_idle", 32'(bus.frame_done), 32'd0);
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.output_is_valid), 32'd0);
    check("rst_pixel", 32'(bus.output_pixel), 32'd0);
    check("rst_trans", 32'(bus.transmission), 32'd0);
    check("rst_fdone", 32'(bus.frame_done), 32'd0);
    check("rst_drop", 32'(bus.drop_err), 32'd0);
    sbq.delete();
    have_a = 0; pend_v = 0; exp_drop = 0; cnt = 0;
`ifdef TE_FRAME_STATS_EN
    s_first = 1'b1;
`endif
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_ale(input int ar, input int ag, input int ab);
    bus.A_R = 8'(ar); bus.A_G = 8'(ag); bus.A_B = 8'(ab);
    bus.Inv_A_R = 16'(65535 / ar);
    bus.Inv_A_G = 16'(65535 / ag);
    bus.Inv_A_B = 16'(65535 / ab);
    bus.ale_valid = 1'b1;
    if (!have_a) begin
      act_r = 65535 / ar; act_g = 65535 / ag; act_b = 65535 / ab;
      have_a = 1;
    end else begin
      pnd_r = 65535 / ar; pnd_g = 65535 / ag; pnd_b = 65535 / ab;
      pend_v = 1;
    end
    @(posedge clk); #1;
    bus.ale_valid = 1'b0;
  endtask

  task automatic drive_pix(input logic [23:0] p);
    exp_s e;
    bus.input_pixel = p;
    bus.input_is_valid = 1'b1;
    if (!have_a) begin
      exp_drop = 1;
    end else begin
      e.pix = p;
      e.t   = 8'(ref_t(int'(p[23:16]), int'(p[15:8]), int'(p[7:0]), act_r, act_g, act_b));
      cnt++;
      e.eof = (cnt == NP);
      e.cyc = cyc;
      sbq.push_back(e);
      if (cnt == NP) begin
        cnt = 0;
        if (pend_v) begin
          act_r = pnd_r; act_g = pnd_g; act_b = pnd_b; pend_v = 0;
        end else begin
          have_a = 0;
        end
      end
    end
    @(posedge clk); #1;
    bus.input_is_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle_quiet(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("quiet_valid", 32'(bus.output_is_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1);
  end

  initial begin
    bus.input_pixel = '0; bus.input_is_valid = 1'b0; bus.ale_valid = 1'b0;
    bus.A_R = '0; bus.A_G = '0; bus.A_B = '0;
    bus.Inv_A_R = '0; bus.Inv_A_G = '0; bus.Inv_A_B = '0;
    #2;
    reset_dut();

    drive_pix(24'h123456);
    idle_quiet(6);
    check("drop_err_set", 32'(bus.drop_err), 32'(exp_drop));

    drive_ale(200, 200, 200);
    drive_pix(24'h646464);
    drive_pix(24'hFFFFFF);
    drive_pix(24'h000000);
    drive_pix(24'hC83296);
    idle(8);
    check("drop_err_sticky", 32'(bus.drop_err), 32'(exp_drop));
    drive_pix(24'h010203);
    idle_quiet(6);

    reset_dut();
    drive_ale(200, 200, 200);
    drive_pix(24'h646464);
    drive_ale(100, 100, 100);
    drive_pix(24'h102030);
    drive_pix(24'hC83296);
    drive_pix(24'hFFFFFF);
    drive_pix(24'h646464);
    drive_pix(24'h050505);
    drive_pix(24'h80FF40);
    drive_pix(24'h000000);
    idle(8);
    check("drop_err_clear", 32'(bus.drop_err), 32'(exp_drop));
    drive_pix(24'hABCDEF);
    idle_quiet(6);
    check("drop_err_wait", 32'(bus.drop_err), 32'(exp_drop));

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)
        drive_ale($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255));
      else if (r < 3)
        idle(1);
      else
        drive_pix(24'($urandom));
    end
    idle(8);
    check("drop_err_rand", 32'(bus.drop_err), 32'(exp_drop));

    reset_dut();
    drive_ale(150, 90, 220);
    drive_pix(24'h4080C0);
    drive_pix(24'hFF1020);
    reset_dut();
    idle_quiet(8);
    drive_ale(120, 240, 60);
    drive_pix(24'h7F7F7F);
    idle(8);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1);
    check("drain", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/transmission_estimator.md
Name: transmission_estimator

Overview:
- Per-pixel transmission-map stage directly downstream of ALE_Top.
- Captures the atmospheric light (A_R/G/B) and its reciprocals (Inv_A_R/G/B) when ALE_Top raises output_is_valid.
- Then streams the frame's pixels and produces t(x) = max(T0, 255 − OMEGA·min_c(I_c/A_c)) in Q0.8, alongside the delayed input pixel, for the scene-recovery stage.

Parameters:
- NUM_PIXELS, 262144, pixels per frame (512×512).
- OMEGA, 243, haze-retention factor in Q0.8 (≈0.95).
- T0, 26, lower clamp on transmission in Q0.8 (≈0.1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- input_pixel  in  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B.
- input_is_valid  in  1  pixel qualifier, one pixel per cycle.
- A_R, A_G, A_B  in  8 each  atmospheric light from ALE_Top.
- Inv_A_R, Inv_A_G, Inv_A_B  in  16 each  floor(65535/A_c) from ALE_Top.
- ale_valid  in  1  ALE_Top output_is_valid; A/Inv_A are valid in this cycle.
- output_pixel  out  24  input_pixel delayed to align with transmission.
- transmission  out  8  t(x), Q0.8.
- output_is_valid  out  1  qualifier for output_pixel/transmission.
- frame_done  out  1  one-cycle pulse with the last pixel's output.
- drop_err  out  1  sticky: a pixel arrived with no A latched.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0; state WAIT_A; pixel counter 0; A/Inv_A registers 0; pending flag 0.
- FSM WAIT_A:
  - ale_valid=1 → latch Inv_A_R/G/B into active registers, go to RUN next cycle.
  - input_is_valid=1 in WAIT_A → pixel discarded, no output, drop_err←1 (sticky until reset).
  - ale_valid and input_is_valid in the same WAIT_A cycle → pixel dropped, drop_err set, A latched.
- FSM RUN:
  - each input_is_valid pixel enters the pipeline and increments the counter.
  - ale_valid in RUN → captured into pending registers, pending←1. The active values are unchanged mid-frame.
  - counter reaching NUM_PIXELS−1 on an accepted pixel → counter←0, and that pixel carries an end-of-frame tag.
  - end of frame with pending=1 → active←pending, pending←0, stay in RUN.
  - end of frame with pending=0 → go to WAIT_A; pixels already in the pipeline still drain.
- Pipeline: 4 stages, fixed latency 4 cycles from accepted input to output_is_valid. No backpressure; bubbles propagate unchanged.
  - S1: p_c = I_c × Inv_A_c, 24-bit unsigned per channel.
  - S2: n_c = p_c >> 8, saturated to 255; m = min(n_R, n_G, n_B).
  - S3: k = (OMEGA × m) >> 8, 8-bit result.
  - S4: t = 255 − k; if t < T0 then t = T0. Drive transmission, output_pixel and output_is_valid; frame_done = end-of-frame tag.
- output_pixel and transmission hold their last value when output_is_valid=0.
- Reset mid-frame: pipeline is flushed, no further outputs, FSM returns to WAIT_A.

Optional Feature:
- TE_FRAME_STATS_EN defined:
  - adds outputs t_min[7:0] and t_max[7:0], updated on every output_is_valid.
  - both are reinitialised at the first output of a frame (t_min=255, t_max=0 before compare).
  - final frame values are stable from frame_done until the next frame's first output.
- TE_FRAME_STATS_EN undefined: ports and logic absent.

Test Plan:
- Reset, ale_valid with A=(200,200,200), Inv=327 each; pixel R=G=B=100 → 4 cycles later transmission=135, output_pixel=0x646464.
- Same A; pixel 0xFFFFFF → n_c saturates to 255, k=242, t=13 clamped → transmission=26. Pixel 0x000000 → transmission=255.
- Same A; pixel R=200,G=50,B=150 → m=63, k=59 → transmission=196. Back-to-back burst of 3 distinct pixels → 3 consecutive valid outputs in order.
- Pixel with input_is_valid before any ale_valid → no output_is_valid, drop_err=1 and stays 1 after a later valid frame.
- NUM_PIXELS=4, ale_valid pulsed mid-frame with A=100 (Inv=655):
  - frame_done pulses on output 4;
  - next frame's R=G=B=100 pixel gives m=255, transmission=13→26;
  - without a new ale_valid after that frame, the FSM returns to WAIT_A.
- Assert rst low with pixels in flight → outputs 0 immediately, no output_is_valid afterwards until a new ale_valid and pixel.
